// File: rtl/xcvr_rst_pkg.sv
// Shared types and cycle constants for the transceiver reset sequencer.
package xcvr_rst_pkg;

  typedef enum logic [2:0] {PLL_PD, WAIT_LOCK, TX_ANA, TX_DIG, TX_RDY} tx_state_t;
  typedef enum logic [1:0] {RX_ANA, RX_WAIT, RX_RDY} rx_state_t;

  // Production cycle counts.
  localparam int DEF_PLL_PD_CYCLES = 1000;
  localparam int DEF_LOCK_STABLE   = 100;
  localparam int DEF_LOCK_TIMEOUT  = 100000;
  localparam int DEF_ANALOG_CYCLES = 100;
  localparam int DEF_LTD_STABLE    = 1000;

  // Shortened counts for simulation.
  localparam int SIM_PLL_PD_CYCLES = 4;
  localparam int SIM_LOCK_STABLE   = 4;
  localparam int SIM_LOCK_TIMEOUT  = 64;
  localparam int SIM_ANALOG_CYCLES = 4;
  localparam int SIM_LTD_STABLE    = 8;

  // Largest of five values, used to size the sequencing counters.
  function automatic int max5(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/sync.sv
// Multi-flop synchroniser for a single asynchronous level input (LENGHT >= 2).
module sync #(
  parameter int   LENGHT = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [LENGHT-1:0] sr_q;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= {LENGHT{INIT}};
    else     sr_q <= {sr_q[LENGHT-2:0], d};
  end

  assign q = sr_q[LENGHT-1];

endmodule

// File: rtl/xcvr_rst_seq.sv
// Transceiver reset sequencer: pulses fPLL powerdown, waits for a stable lock,
// then releases TX analog/digital resets, followed by RX resets once the CDR
// holds lock-to-data. Re-sequences on loss of PLL or CDR lock.
module xcvr_rst_seq
  import xcvr_rst_pkg::*;
#(
  parameter int PLL_PD_CYCLES = DEF_PLL_PD_CYCLES,
  parameter int LOCK_STABLE   = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int ANALOG_CYCLES = DEF_ANALOG_CYCLES,
  parameter int LTD_STABLE    = DEF_LTD_STABLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       pll_cal_busy,
  input  logic       tx_cal_busy,
  input  logic       rx_cal_busy,
  input  logic       rx_is_lockedtodata,
  output logic       pll_powerdown,
  output logic       tx_analogreset,
  output logic       tx_digitalreset,
  output logic       rx_analogreset,
  output logic       rx_digitalreset,
  output logic       tx_ready,
  output logic       rx_ready,
  output logic [7:0] lock_timeout_cnt
);

  localparam int CNT_W = $clog2(max5(PLL_PD_CYCLES, LOCK_STABLE, LOCK_TIMEOUT,
                                     ANALOG_CYCLES, LTD_STABLE)) + 1;

  // Terminal counts: a phase of N cycles ends when its counter reads N-1.
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PD_LAST     = CNT_W'(PLL_PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ANA_LAST    = CNT_W'(ANALOG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LTD_LAST    = CNT_W'(LTD_STABLE - 1);

  // Synchronised status inputs, bit order matches async_in.
  logic [4:0] async_in;
  logic [4:0] sync_q;
  assign async_in = {rx_is_lockedtodata, rx_cal_busy, tx_cal_busy, pll_cal_busy, pll_locked};

  for (genvar gi = 0; gi < 5; gi++) begin : g_sync
    sync #(.LENGHT(2), .INIT(1'b0)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (async_in[gi]),
      .q   (sync_q[gi])
    );
  end

  logic locked_s, pll_cal_s, tx_cal_s, rx_cal_s, ltd_s;
  assign locked_s  = sync_q[0];
  assign pll_cal_s = sync_q[1];
  assign tx_cal_s  = sync_q[2];
  assign rx_cal_s  = sync_q[3];
  assign ltd_s     = sync_q[4];

  tx_state_t        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;     // phase counter (powerdown, lock-stable, analog wait)
  logic [CNT_W-1:0] tx_tmr_q;     // WAIT_LOCK timeout timer, not cleared by lock glitches
  logic             pd_q, txa_q, txd_q, txr_q;
  logic [7:0]       to_cnt_q;

  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic             rxa_q, rxd_q, rxr_q;

  logic lock_ok, tx_up;
  assign lock_ok = locked_s && !pll_cal_s;
  // RX may only run while TX has at least released its digital reset.
  assign tx_up   = (tx_state_q == TX_DIG) || (tx_state_q == TX_RDY);

  // TX sequencing FSM with registered reset/ready outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= PLL_PD;
      tx_cnt_q   <= '0;
      tx_tmr_q   <= '0;
      pd_q       <= 1'b1;
      txa_q      <= 1'b1;
      txd_q      <= 1'b1;
      txr_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else if (tx_state_q inside {TX_ANA, TX_DIG, TX_RDY} && !locked_s) begin
      // Lost lock: restart from lock wait, powerdown is not re-pulsed.
      tx_state_q <= WAIT_LOCK;
      tx_cnt_q   <= '0;
      tx_tmr_q   <= '0;
      txa_q      <= 1'b1;
      txd_q      <= 1'b1;
      txr_q      <= 1'b0;
    end else begin
      case (tx_state_q)
        PLL_PD: begin
          if (tx_cnt_q == PD_LAST) begin
            tx_state_q <= WAIT_LOCK;
            tx_cnt_q   <= '0;
            tx_tmr_q   <= '0;
            pd_q       <= 1'b0;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          // Stable-lock completion wins over a coincident timeout.
          if (lock_ok && tx_cnt_q == STABLE_LAST) begin
            tx_state_q <= TX_ANA;
            tx_cnt_q   <= '0;
            txa_q      <= 1'b0;
          end else if (tx_tmr_q == TMO_LAST) begin
            tx_state_q <= PLL_PD;
            tx_cnt_q   <= '0;
            tx_tmr_q   <= '0;
            pd_q       <= 1'b1;
            if (to_cnt_q != 8'hFF) to_cnt_q <= to_cnt_q + 8'd1;
          end else begin
            tx_tmr_q <= tx_tmr_q + CNT_ONE;
            tx_cnt_q <= lock_ok ? tx_cnt_q + CNT_ONE : '0;
          end
        end
        TX_ANA: begin
          if (tx_cal_s) begin
            tx_cnt_q <= '0;
          end else if (tx_cnt_q == ANA_LAST) begin
            tx_state_q <= TX_DIG;
            tx_cnt_q   <= '0;
            txd_q      <= 1'b0;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        TX_DIG: begin
          tx_state_q <= TX_RDY;
          tx_cnt_q   <= '0;
          txr_q      <= 1'b1;
        end
        TX_RDY: begin
          tx_cnt_q <= '0;
        end
        default: begin
          tx_state_q <= PLL_PD;
          tx_cnt_q   <= '0;
          pd_q       <= 1'b1;
        end
      endcase
    end
  end

  // RX sequencing FSM, gated by the TX FSM being out of digital reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_ANA;
      rx_cnt_q   <= '0;
      rxa_q      <= 1'b1;
      rxd_q      <= 1'b1;
      rxr_q      <= 1'b0;
    end else if (!tx_up) begin
      rx_state_q <= RX_ANA;
      rx_cnt_q   <= '0;
      rxa_q      <= 1'b1;
      rxd_q      <= 1'b1;
      rxr_q      <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_ANA: begin
          rxa_q <= 1'b0;
          if (rx_cal_s) begin
            rx_cnt_q <= '0;
          end else if (rx_cnt_q == ANA_LAST) begin
            rx_state_q <= RX_WAIT;
            rx_cnt_q   <= '0;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        RX_WAIT: begin
          if (!ltd_s) begin
            rx_cnt_q <= '0;
          end else if (rx_cnt_q == LTD_LAST) begin
            rx_state_q <= RX_RDY;
            rx_cnt_q   <= '0;
            rxd_q      <= 1'b0;
            rxr_q      <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        RX_RDY: begin
          // CDR lock lost: only the digital side re-enters reset.
          if (!ltd_s) begin
            rx_state_q <= RX_WAIT;
            rx_cnt_q   <= '0;
            rxd_q      <= 1'b1;
            rxr_q      <= 1'b0;
          end
        end
        default: begin
          rx_state_q <= RX_ANA;
          rx_cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pll_powerdown    = pd_q;
  assign tx_analogreset   = txa_q;
  assign tx_digitalreset  = txd_q;
  assign rx_analogreset   = rxa_q;
  assign rx_digitalreset  = rxd_q;
  assign tx_ready         = txr_q;
  assign rx_ready         = rxr_q;
  assign lock_timeout_cnt = to_cnt_q;

endmodule

// File: tb/tb_xcvr_rst_seq.sv
// Directed bench for xcvr_rst_seq using the simulation cycle set.
module tb_xcvr_rst_seq;
  import xcvr_rst_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_cal_busy = 1'b0;
  logic       tx_cal_busy = 1'b0;
  logic       rx_cal_busy = 1'b0;
  logic       rx_is_lockedtodata = 1'b0;
  logic       pll_powerdown, tx_analogreset, tx_digitalreset;
  logic       rx_analogreset, rx_digitalreset, tx_ready, rx_ready;
  logic [7:0] lock_timeout_cnt;

  xcvr_rst_seq #(
    .PLL_PD_CYCLES (SIM_PLL_PD_CYCLES),
    .LOCK_STABLE   (SIM_LOCK_STABLE),
    .LOCK_TIMEOUT  (SIM_LOCK_TIMEOUT),
    .ANALOG_CYCLES (SIM_ANALOG_CYCLES),
    .LTD_STABLE    (SIM_LTD_STABLE)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pll_locked         (pll_locked),
    .pll_cal_busy       (pll_cal_busy),
    .tx_cal_busy        (tx_cal_busy),
    .rx_cal_busy        (rx_cal_busy),
    .rx_is_lockedtodata (rx_is_lockedtodata),
    .pll_powerdown      (pll_powerdown),
    .tx_analogreset     (tx_analogreset),
    .tx_digitalreset    (tx_digitalreset),
    .rx_analogreset     (rx_analogreset),
    .rx_digitalreset    (rx_digitalreset),
    .tx_ready           (tx_ready),
    .rx_ready           (rx_ready),
    .lock_timeout_cnt   (lock_timeout_cnt)
  );

  always #5 clk = ~clk;

  // Number of rising edges since rst was released.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Bit order: 0 pd, 1 tx_ana, 2 tx_dig, 3 rx_ana, 4 rx_dig, 5 tx_ready, 6 rx_ready
  logic [6:0] outs;
  assign outs = {rx_ready, tx_ready, rx_digitalreset, rx_analogreset,
                 tx_digitalreset, tx_analogreset, pll_powerdown};

  int         n_checks = 0;
  int         n_errors = 0;
  int         rise_at[7];
  int         fall_at[7];
  int         rise_n[7];
  logic [6:0] prev_outs;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic clear_rec();
    for (int i = 0; i < 7; i++) begin
      rise_at[i] = 0;
      fall_at[i] = 0;
      rise_n[i]  = 0;
    end
    prev_outs = outs;
  endtask

  // Advance to the next falling edge and record output transitions.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      if (outs[i] && !prev_outs[i]) begin
        rise_at[i] = cyc;
        rise_n[i]++;
      end
      if (!outs[i] && prev_outs[i]) fall_at[i] = cyc;
    end
    prev_outs = outs;
  endtask

  task automatic run_to(input int c);
    for (int g = 0; g < 30000 && cyc < c; g++) step();
    chk("run_to_reached", cyc, c);
  endtask

  task automatic do_reset(input logic tx_cal, input logic ltd);
    rst                = 1'b1;
    pll_locked         = 1'b0;
    pll_cal_busy       = 1'b0;
    tx_cal_busy        = tx_cal;
    rx_cal_busy        = 1'b0;
    rx_is_lockedtodata = ltd;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_rec();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_pd"},     int'(pll_powerdown), 1);
    chk({pfx, "_tx_ana"}, int'(tx_analogreset), 1);
    chk({pfx, "_tx_dig"}, int'(tx_digitalreset), 1);
    chk({pfx, "_rx_ana"}, int'(rx_analogreset), 1);
    chk({pfx, "_rx_dig"}, int'(rx_digitalreset), 1);
    chk({pfx, "_tx_rdy"}, int'(tx_ready), 0);
    chk({pfx, "_rx_rdy"}, int'(rx_ready), 0);
    chk({pfx, "_to_cnt"}, int'(lock_timeout_cnt), 0);
  endtask

  initial begin
    // 1: power-up sequence, lock at cycle 20.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("t1_rst");
    do_reset(1'b0, 1'b1);
    run_to(20);
    pll_locked = 1'b1;
    run_to(60);
    chk("t1_pd_fall",       fall_at[0], 4);
    chk("t1_pd_rises",      rise_n[0], 0);
    chk("t1_tx_ana_fall",   fall_at[1], 26);
    chk("t1_tx_dig_fall",   fall_at[2], 30);
    chk("t1_tx_rdy_rise",   rise_at[5], 31);
    chk("t1_rx_ana_fall",   fall_at[3], 31);
    chk("t1_rx_dig_fall",   fall_at[4], 42);
    chk("t1_rx_rdy_rise",   rise_at[6], 42);
    chk("t1_to_cnt",        int'(lock_timeout_cnt), 0);

    // 3: one-cycle loss of PLL lock while fully up.
    clear_rec();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    run_to(62);
    chk("t3_tx_rdy_held",   int'(tx_ready), 1);
    run_to(63);
    chk("t3_tx_rdy_drop",   int'(tx_ready), 0);
    chk("t3_tx_ana_re",     int'(tx_analogreset), 1);
    chk("t3_tx_dig_re",     int'(tx_digitalreset), 1);
    run_to(64);
    chk("t3_rx_rdy_drop",   int'(rx_ready), 0);
    chk("t3_rx_ana_re",     int'(rx_analogreset), 1);
    chk("t3_rx_dig_re",     int'(rx_digitalreset), 1);
    run_to(100);
    chk("t3_no_pd_pulse",   rise_n[0], 0);
    chk("t3_tx_ana_fall",   fall_at[1], 67);
    chk("t3_tx_rdy_rise",   rise_at[5], 72);
    chk("t3_rx_rdy_rise",   rise_at[6], 83);

    // 5: loss of CDR lock while fully up.
    do_reset(1'b0, 1'b1);
    run_to(20);
    pll_locked = 1'b1;
    run_to(60);
    chk("t5_rx_rdy_up",     int'(rx_ready), 1);
    rx_is_lockedtodata = 1'b0;
    run_to(62);
    chk("t5_rx_dig_early",  int'(rx_digitalreset), 0);
    run_to(63);
    chk("t5_rx_dig_re",     int'(rx_digitalreset), 1);
    chk("t5_rx_rdy_drop",   int'(rx_ready), 0);
    chk("t5_rx_ana_held",   int'(rx_analogreset), 0);
    chk("t5_tx_rdy_held",   int'(tx_ready), 1);
    clear_rec();
    rx_is_lockedtodata = 1'b1;
    run_to(80);
    chk("t5_rx_rdy_rise",   rise_at[6], 73);
    chk("t5_rx_ana_quiet",  rise_n[3], 0);

    // 4: lock glitching low every third cycle never completes the stable count.
    do_reset(1'b0, 1'b1);
    run_to(8);
    for (int g = 0; g < 100 && cyc < 70; g++) begin
      pll_locked = (cyc % 3) != 0;
      step();
    end
    chk("t4_cyc_end",       cyc, 70);
    chk("t4_tx_ana_never",  fall_at[1], 0);
    chk("t4_tx_rdy_never",  rise_n[5], 0);
    chk("t4_pd_repulse",    rise_at[0], 68);
    chk("t4_to_cnt",        int'(lock_timeout_cnt), 1);

    // 2: PLL never locks; periodic re-pulse and saturating timeout count.
    do_reset(1'b0, 1'b0);
    run_to(209);
    chk("t2_pd_rises",      rise_n[0], 3);
    chk("t2_pd_last_rise",  rise_at[0], 204);
    chk("t2_pd_last_fall",  fall_at[0], 208);
    chk("t2_to_cnt_3",      int'(lock_timeout_cnt), 3);
    run_to(68 * 254 + 2);
    chk("t2_to_cnt_254",    int'(lock_timeout_cnt), 254);
    run_to(68 * 256 + 2);
    chk("t2_to_cnt_sat",    int'(lock_timeout_cnt), 255);
    run_to(68 * 300 + 2);
    chk("t2_to_cnt_300",    int'(lock_timeout_cnt), 255);
    chk("t2_pd_rises_300",  rise_n[0], 300);

    // 6: asynchronous reset while stuck in TX_ANA on TX calibration.
    do_reset(1'b1, 1'b1);
    run_to(20);
    pll_locked = 1'b1;
    run_to(40);
    chk("t6_tx_ana_low",    int'(tx_analogreset), 0);
    chk("t6_tx_dig_stuck",  int'(tx_digitalreset), 1);
    chk("t6_pd_low",        int'(pll_powerdown), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("t6_async");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
